// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared state, owner and arbitration-mode codes for the data RAM arbiter
package dram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_HOST = 1'b1;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
endpackage

// File: rtl/dram_arbiter_arb_pick2.sv
// arb_pick2: combinational two-way picker returning the winning owner code
module arb_pick2
  import dram_arb_pkg::*;
#(
  parameter int MODE = ARB_RR
) (
  input  logic i_req_c,
  input  logic i_req_h,
  input  logic i_last,
  output logic o_win
);
  logic w_tie;
  assign w_tie = i_req_c && i_req_h;
  // On a tie round-robin hands the grant to whoever did not have it last
  assign o_win = w_tie ? ((MODE == ARB_FIXED) ? OWN_CPU : ~i_last) : (i_req_c ? OWN_CPU : OWN_HOST);
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the CPU LD/ST path and the host port,
// sequencing the RAM's registered-address timing and returning read data with a one-cycle ack
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic          busy,
  output logic          owner
);
  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_we;
  logic          r_wr;
  logic          r_c_ack;
  logic          r_h_ack;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_h_rdata;
  logic          r_busy;
  logic          r_owner;
  logic          w_win;
  arb_pick2 #(.MODE(ARB_MODE)) u_pick (
    .i_req_c(c_req),
    .i_req_h(h_req),
    .i_last (r_owner),
    .o_win  (w_win)
  );
  // owner doubles as the last grantee, so it resets to host and the CPU wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_wr      <= 1'b0;
      r_c_ack   <= 1'b0;
      r_h_ack   <= 1'b0;
      r_c_rdata <= '0;
      r_h_rdata <= '0;
      r_busy    <= 1'b0;
      r_owner   <= OWN_HOST;
    end else begin
      case (r_state)
        IDLE: if (c_req || h_req) begin
          r_owner <= w_win;
          r_wr    <= w_win ? h_we : c_we;
          r_we    <= w_win ? h_we : c_we;
          r_addr  <= w_win ? h_addr : c_addr;
          r_data  <= w_win ? h_wdata : c_wdata;
          r_busy  <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_we    <= 1'b0;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (!r_wr && r_owner == OWN_CPU) r_c_rdata <= ram_q;
          if (!r_wr && r_owner == OWN_HOST) r_h_rdata <= ram_q;
          r_c_ack <= r_owner == OWN_CPU;
          r_h_ack <= r_owner == OWN_HOST;
          r_state <= DONE;
        end
        default: begin
          r_c_ack <= 1'b0;
          r_h_ack <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign ram_addr = r_addr;
  assign ram_data = r_data;
  assign ram_we   = r_we;
  assign c_ack    = r_c_ack;
  assign h_ack    = r_h_ack;
  assign c_rdata  = r_c_rdata;
  assign h_rdata  = r_h_rdata;
  assign busy     = r_busy;
  assign owner    = r_owner;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed checks of both arbitration modes against behavioural RAM models
module tb_dram_arbiter;
  import dram_arb_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic c_req = 0, c_we = 0, h_req = 0, h_we = 0, f_c_req = 0, f_h_req = 0;
  logic [15:0] c_addr = 0, c_wdata = 0, h_addr = 0, h_wdata = 0;
  logic c_ack, h_ack, ram_we, busy, owner;
  logic [15:0] c_rdata, h_rdata, ram_addr, ram_data, ram_q;
  logic f_c_ack, f_h_ack, f_ram_we, f_busy, f_owner;
  logic [15:0] f_c_rdata, f_h_rdata, f_ram_addr, f_ram_data, f_ram_q;
  logic pl_en = 0;
  logic [15:0] pl_addr = 0, pl_data = 0;
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  logic [15:0] ra0, ra1;
  int vec = 0, bad = 0;

  dram_arbiter #(.DW(16), .AW(16), .ARB_MODE(ARB_RR)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q), .busy(busy), .owner(owner)
  );
  dram_arbiter #(.DW(16), .AW(16), .ARB_MODE(ARB_FIXED)) dut_fixed (
    .clock(clock), .reset(reset),
    .c_req(f_c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(f_c_ack), .c_rdata(f_c_rdata),
    .h_req(f_h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_ack(f_h_ack), .h_rdata(f_h_rdata),
    .ram_addr(f_ram_addr), .ram_data(f_ram_data), .ram_we(f_ram_we), .ram_q(f_ram_q), .busy(f_busy), .owner(f_owner)
  );

  // RAM: registered address, write-first, unregistered output
  always @(posedge clock) begin
    if (ram_we) mem0[ram_addr] <= ram_data;
    else if (pl_en) mem0[pl_addr] <= pl_data;
    ra0 <= ram_addr;
  end
  always @(posedge clock) begin
    if (f_ram_we) mem1[f_ram_addr] <= f_ram_data;
    else if (pl_en) mem1[pl_addr] <= pl_data;
    ra1 <= f_ram_addr;
  end
  assign ram_q = mem0[ra0];
  assign f_ram_q = mem1[ra1];

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    pl_en = 1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic cpu_read_check(input logic [15:0] a, input logic [15:0] exp);
    @(negedge clock);
    c_req = 1; c_we = 0; c_addr = a;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      vec++;
      if (c_ack !== (k == 3)) begin bad++; $display("FAIL cpu_read_ack c%0d: got %b want %b", k, c_ack, k == 3); end
      if (k == 3) begin
        vec++;
        if (c_rdata !== exp) begin bad++; $display("FAIL cpu_read_data @%h: got %h want %h", a, c_rdata, exp); end
        c_req = 0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    vec++;
    if ({ram_addr, ram_data} !== 32'h0) begin bad++; $display("FAIL reset_ram_bus: got %h want 0", {ram_addr, ram_data}); end
    vec++;
    if ({ram_we, c_ack, h_ack, busy, owner} !== 5'b00001) begin bad++; $display("FAIL reset_ctrl: got %b want 00001", {ram_we, c_ack, h_ack, busy, owner}); end
    vec++;
    if ({c_rdata, h_rdata} !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {c_rdata, h_rdata}); end
    vec++;
    if ({f_ram_we, f_c_ack, f_h_ack, f_busy, f_owner} !== 5'b00001) begin bad++; $display("FAIL reset_fixed_ctrl: got %b want 00001", {f_ram_we, f_c_ack, f_h_ack, f_busy, f_owner}); end
    reset = 0;
  endtask

  task automatic test_cpu_read();
    preload(16'h0012, 16'hBEEF);
    @(negedge clock);
    c_req = 1; c_we = 0; c_addr = 16'h0012;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      vec++;
      if ({c_ack, h_ack} !== {k == 3, 1'b0}) begin bad++; $display("FAIL cpu_read_acks c%0d: got %b want %b", k, {c_ack, h_ack}, {k == 3, 1'b0}); end
      vec++;
      if (busy !== (k != 4)) begin bad++; $display("FAIL cpu_read_busy c%0d: got %b want %b", k, busy, k != 4); end
      if (k == 1) begin
        vec++;
        if ({ram_addr, owner} !== {16'h0012, OWN_CPU}) begin bad++; $display("FAIL cpu_read_issue: got %h/%b want 0012/0", ram_addr, owner); end
      end
      if (k == 3) begin
        vec++;
        if (c_rdata !== 16'hBEEF) begin bad++; $display("FAIL cpu_read_data: got %h want beef", c_rdata); end
        c_req = 0;
      end
    end
  endtask

  task automatic test_host_write_cpu_read();
    @(negedge clock);
    h_req = 1; h_we = 1; h_addr = 16'h0040; h_wdata = 16'h1234;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      vec++;
      if ({ram_we, h_ack, c_ack} !== {k == 1, k == 3, 1'b0}) begin bad++; $display("FAIL host_write c%0d: got %b want %b", k, {ram_we, h_ack, c_ack}, {k == 1, k == 3, 1'b0}); end
      if (k == 1) begin
        vec++;
        if ({ram_addr, ram_data, owner} !== {16'h0040, 16'h1234, OWN_HOST}) begin bad++; $display("FAIL host_write_bus: got %h/%h/%b want 0040/1234/1", ram_addr, ram_data, owner); end
      end
      if (k == 3) begin
        vec++;
        if (h_rdata !== 16'h0) begin bad++; $display("FAIL host_write_rdata: got %h want 0", h_rdata); end
        h_req = 0; h_we = 0;
      end
    end
    cpu_read_check(16'h0040, 16'h1234);
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clock);
    c_req = 1; c_we = 0; c_addr = 16'h0012;
    h_req = 1; h_we = 0; h_addr = 16'h0040;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      vec++;
      if ({c_ack, h_ack} !== {k == 3 || k == 11, k == 7 || k == 15}) begin bad++; $display("FAIL rr_acks c%0d: got %b want %b", k, {c_ack, h_ack}, {k == 3 || k == 11, k == 7 || k == 15}); end
      if (k == 3) begin
        vec++;
        if (c_rdata !== 16'hBEEF) begin bad++; $display("FAIL rr_cpu_data: got %h want beef", c_rdata); end
      end
      if (k == 7) begin
        vec++;
        if (h_rdata !== 16'h1234) begin bad++; $display("FAIL rr_host_data: got %h want 1234", h_rdata); end
      end
    end
    c_req = 0; h_req = 0;
  endtask

  task automatic test_fixed_priority();
    @(negedge clock);
    f_c_req = 1; f_h_req = 1; c_we = 0; c_addr = 16'h0012; h_we = 0; h_addr = 16'h0040;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      vec++;
      if ({f_c_ack, f_h_ack} !== {k % 4 == 3, 1'b0}) begin bad++; $display("FAIL fixed_acks c%0d: got %b want %b", k, {f_c_ack, f_h_ack}, {k % 4 == 3, 1'b0}); end
    end
    vec++;
    if ({f_c_rdata, f_owner} !== {16'hBEEF, OWN_CPU}) begin bad++; $display("FAIL fixed_data: got %h/%b want beef/0", f_c_rdata, f_owner); end
    f_c_req = 0; f_h_req = 0;
  endtask

  task automatic test_write_keeps_rdata();
    @(negedge clock);
    c_req = 1; c_we = 1; c_addr = 16'h0060; c_wdata = 16'h5555;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      vec++;
      if (c_ack !== (k == 3)) begin bad++; $display("FAIL cpu_write_ack c%0d: got %b want %b", k, c_ack, k == 3); end
      if (k == 3) begin c_req = 0; c_we = 0; end
    end
    vec++;
    if ({c_rdata, h_rdata} !== {16'hBEEF, 16'h1234}) begin bad++; $display("FAIL write_keeps_rdata: got %h want beef1234", {c_rdata, h_rdata}); end
    cpu_read_check(16'h0060, 16'h5555);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clock);
    h_req = 1; h_we = 0; h_addr = 16'h0040;
    repeat (2) @(negedge clock);
    reset = 1; h_req = 0;
    @(negedge clock);
    reset = 0;
    vec++;
    if ({busy, h_ack, ram_we} !== 3'b000) begin bad++; $display("FAIL reset_mid_ctrl: got %b want 000", {busy, h_ack, ram_we}); end
    vec++;
    if (h_rdata !== 16'h0) begin bad++; $display("FAIL reset_mid_rdata: got %h want 0", h_rdata); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      vec++;
      if ({h_ack, c_ack} !== 2'b00) begin bad++; $display("FAIL reset_mid_noack %0d: got %b want 00", k, {h_ack, c_ack}); end
    end
  endtask

  task automatic test_reset_in_issue();
    preload(16'h0078, 16'h0000);
    @(negedge clock);
    h_req = 1; h_we = 1; h_addr = 16'h0077; h_wdata = 16'hABCD;
    @(negedge clock);
    vec++;
    if (ram_we !== 1'b1) begin bad++; $display("FAIL issue_we: got %b want 1", ram_we); end
    reset = 1; h_req = 0; h_we = 0;
    @(negedge clock);
    reset = 0;
    vec++;
    if ({ram_we, busy} !== 2'b00) begin bad++; $display("FAIL issue_reset: got %b want 00", {ram_we, busy}); end
    cpu_read_check(16'h0077, 16'hABCD);
    @(negedge clock);
    h_req = 1; h_we = 1; h_addr = 16'h0078; h_wdata = 16'h5A5A; reset = 1;
    @(negedge clock);
    reset = 0; h_req = 0; h_we = 0;
    vec++;
    if ({ram_we, busy} !== 2'b00) begin bad++; $display("FAIL grant_reset: got %b want 00", {ram_we, busy}); end
    cpu_read_check(16'h0078, 16'h0000);
  endtask

  task automatic test_dropped_req();
    @(negedge clock);
    c_req = 1; c_we = 0; c_addr = 16'h0040;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      c_req = 0;
      vec++;
      if ({c_ack, busy} !== {k == 3, k != 4}) begin bad++; $display("FAIL dropped_req c%0d: got %b want %b", k, {c_ack, busy}, {k == 3, k != 4}); end
      if (k == 3) begin
        vec++;
        if (c_rdata !== 16'h1234) begin bad++; $display("FAIL dropped_req_data: got %h want 1234", c_rdata); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_host_write_cpu_read();
    test_round_robin();
    test_fixed_priority();
    test_write_keeps_rdata();
    test_reset_mid_access();
    test_reset_in_issue();
    test_dropped_req();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
